rv32_writeback_unit: RTL
========================

// Module: rv32_writeback_unit
// PURPOSE
// - Writer side of the RV32I register file: MEM/WB stage that selects the result, aligns/extends loads, drives the file write port.
// - Sits between the MEM stage / data-memory response and the register file (which writes on negedge clk).
// - Registers all outputs on posedge so they are stable at the file's negedge write.
// PARAMETERS
// - XLEN          32  datapath width
// - LOAD_TIMEOUT  16  max cycles in WAIT_LOAD before abort (>=1)
// - CNT_W         32  width of retire counter
// PORTS
// - clk            in   1     clock, posedge
// - reset_n        in   1     async active-low reset
// - mem_valid      in   1     MEM stage offers an instruction
// - mem_ready      out  1     unit can accept (combinational, = state==IDLE)
// - mem_rd         in   5     destination register
// - mem_reg_write  in   1     instruction writes rd
// - mem_wb_sel     in   2     00 ALU, 01 LOAD, 10 PC+4, 11 IMM (LUI)
// - mem_alu_result in   XLEN  ALU result; [1:0] = load byte offset
// - mem_pc_plus4   in   XLEN  link value
// - mem_imm        in   XLEN  U-immediate
// - mem_funct3     in   3     load type
// - dmem_rvalid    in   1     data-memory read response valid
// - dmem_rdata     in   XLEN  raw aligned word
// - rf_reg_write   out  1     write strobe to register file (one-cycle)
// - rf_rd          out  5     write address
// - rf_write_data  out  XLEN  write data
// - load_err       out  1     one-cycle pulse: misaligned/illegal funct3/timeout
// - retire_cnt     out  CNT_W completed instructions, wraps
// BEHAVIOUR
// - Reset: state IDLE; rf_reg_write=0, rf_rd=0, rf_write_data=0, load_err=0, retire_cnt=0, timeout counter=0.
// - Accept on mem_valid && mem_ready; fields latched same edge.
// - FSM IDLE -> (wb_sel!=LOAD) WRITE | (wb_sel==LOAD) WAIT_LOAD; WAIT_LOAD -> WRITE on dmem_rvalid or timeout; WRITE -> IDLE.
// - Non-load latency: rf_reg_write high the cycle after accept. Load: high the cycle after dmem_rvalid.
// - rf_reg_write high exactly one cycle in WRITE iff mem_reg_write && rd!=0 && no error; rd==0 completes with no strobe.
// - Load extract: LB 000 / LBU 100 byte[off]; LH 001 / LHU 101 half[off[1]]; LW 010 whole word; signed -> sign-extend, else zero.
// - Errors: LH/LHU off[0]=1, LW off!=0, funct3 in {011,110,111} -> load_err pulse, no write; detected at accept, skip WAIT_LOAD.
// - Timeout: counter clears on entry to WAIT_LOAD; reaching LOAD_TIMEOUT without rvalid -> load_err, no write, to WRITE.
// - retire_cnt +1 on every exit from WRITE (errored included); wraps 2^CNT_W-1 -> 0.
// - dmem_rvalid outside WAIT_LOAD ignored (stale/late responses); rvalid and timeout same cycle -> rvalid wins.
// - Reset mid-operation: instruction dropped, no write, any later rvalid ignored.
// - rf_rd / rf_write_data hold last values when strobe low.
// STRUCTURE
// - rv32_pkg: WB_SEL_* encodings, LOAD_F3_* codes, wb_state_t (IDLE/WAIT_LOAD/WRITE), XLEN.
// - Sub-module rv32_load_align: combinational funct3+offset+word -> extended data + misalign flag.
// TESTING
// - ALU: rd=5, wb_sel=00, alu=0x1234 -> next cycle rf_reg_write=1, rf_rd=5, data=0x00001234; retire_cnt=1.
// - LB/LBU: off=3, rdata=0x80FF_0000 -> LB 0xFFFFFF80, LBU 0x00000080, strobe cycle after rvalid.
// - LH off=1 -> load_err pulse, no strobe, mem_ready back after 2 cycles; LW off=0, rdata=0xDEADBEEF -> 0xDEADBEEF.
// - Timeout: load with no rvalid -> load_err at cycle LOAD_TIMEOUT, no write; late rvalid in IDLE ignored.
// - rd=0, JAL wb_sel=10 -> no strobe, retire_cnt increments; rd=1 JAL pc+4=0x104 -> data 0x104.
// - reset_n low during WAIT_LOAD -> all outputs 0 immediately; subsequent rvalid produces no write.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared encodings for the RV32I writeback stage
//   XLEN          datapath width
//   WB_SEL_*      result source select carried down from decode
//   LOAD_F3_*     funct3 codes of the RV32I load instructions
//   wb_state_t    writeback sequencer states
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    localparam logic [2:0] LOAD_F3_LB  = 3'b000;
    localparam logic [2:0] LOAD_F3_LH  = 3'b001;
    localparam logic [2:0] LOAD_F3_LW  = 3'b010;
    localparam logic [2:0] LOAD_F3_LBU = 3'b100;
    localparam logic [2:0] LOAD_F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOAD,
        WRITE
    } wb_state_t;

endpackage

// File: rtl/rv32_load_align.sv
// rv32_load_align: extracts and extends load data from an aligned memory word
//   funct3    in   load type (LB/LH/LW/LBU/LHU)
//   offset    in   byte offset inside the word (address bits [1:0])
//   word      in   raw aligned word from data memory
//   data      out  extracted, sign- or zero-extended result
//   misalign  out  access not naturally aligned, or funct3 is not a load
module rv32_load_align
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    // Shifting the addressed byte down to bit 0 serves both byte and
    // halfword loads; a legal halfword only ever has offset 0 or 2.
    logic [15:0] low;

    assign low = 16'(word >> {offset, 3'b000});

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (funct3)
            LOAD_F3_LB:  data = {{(XLEN-8){low[7]}}, low[7:0]};
            LOAD_F3_LBU: data = {{(XLEN-8){1'b0}}, low[7:0]};
            LOAD_F3_LH: begin
                data     = {{(XLEN-16){low[15]}}, low};
                misalign = offset[0];
            end
            LOAD_F3_LHU: begin
                data     = {{(XLEN-16){1'b0}}, low};
                misalign = offset[0];
            end
            LOAD_F3_LW: begin
                data     = word;
                misalign = |offset;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32_writeback_unit.sv
// rv32_writeback_unit: MEM/WB stage driving the RV32I register-file write port
//   clk, reset_n      clock (posedge) and asynchronous active-low reset
//   mem_valid/ready   handshake with the MEM stage (ready only when idle)
//   mem_rd            destination register
//   mem_reg_write     instruction writes rd
//   mem_wb_sel        result source: ALU / LOAD / PC+4 / IMM
//   mem_alu_result    ALU result, low two bits double as load byte offset
//   mem_pc_plus4      link value for JAL/JALR
//   mem_imm           U-immediate for LUI
//   mem_funct3        load type
//   dmem_rvalid/rdata data-memory read response
//   rf_reg_write      one-cycle write strobe to the register file
//   rf_rd             write address (held while strobe is low)
//   rf_write_data     write data (held while strobe is low)
//   load_err          one-cycle pulse on misaligned/illegal load or timeout
//   retire_cnt        count of completed instructions, wraps
// All file-facing outputs are registered so they are stable when the
// register file samples them on the falling edge.
module rv32_writeback_unit
    import rv32_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [1:0]       mem_wb_sel,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [XLEN-1:0]  mem_imm,
    input  logic [2:0]       mem_funct3,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             rf_reg_write,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_write_data,
    output logic             load_err,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int TW = $clog2(LOAD_TIMEOUT + 1);

    wb_state_t state, state_next;

    logic [4:0]      q_rd;
    logic            q_reg_write;
    logic [2:0]      q_funct3;
    logic [1:0]      q_offset;
    logic [TW-1:0]   t_cnt;

    logic            accept, is_load, in_wait, rvalid_hit, timeout, bad_load;
    logic [2:0]      al_funct3;
    logic [1:0]      al_offset;
    logic [XLEN-1:0] al_data;
    logic            al_misalign;

    logic            strobe_d, err_d;
    logic [4:0]      rd_d;
    logic [XLEN-1:0] data_d;

    assign mem_ready  = state == IDLE;
    assign accept     = mem_valid && mem_ready;
    assign is_load    = mem_wb_sel == WB_SEL_LOAD;
    assign in_wait    = state == WAIT_LOAD;
    assign rvalid_hit = in_wait && dmem_rvalid;
    // A response arriving in the final wait cycle still completes the load.
    assign timeout    = in_wait && !dmem_rvalid && t_cnt == TW'(LOAD_TIMEOUT - 1);

    // One aligner serves both jobs: while idle it screens the incoming
    // instruction for a bad access, while waiting it formats the response.
    assign al_funct3 = mem_ready ? mem_funct3 : q_funct3;
    assign al_offset = mem_ready ? mem_alu_result[1:0] : q_offset;
    assign bad_load  = accept && is_load && al_misalign;

    rv32_load_align #(
        .XLEN(XLEN)
    ) u_align (
        .funct3   (al_funct3),
        .offset   (al_offset),
        .word     (dmem_rdata),
        .data     (al_data),
        .misalign (al_misalign)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Faulty loads go straight to WRITE so they retire without a memory wait.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = (is_load && !al_misalign) ? WAIT_LOAD : WRITE;
            WAIT_LOAD: if (dmem_rvalid || timeout) state_next = WRITE;
            WRITE:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; they become visible in WRITE.
    always_comb begin
        strobe_d = (accept && !is_load && mem_reg_write && mem_rd != '0)
                || (rvalid_hit && q_reg_write && q_rd != '0);
        err_d    = bad_load || timeout;
        rd_d     = rvalid_hit ? q_rd : mem_rd;
        data_d   = rvalid_hit                 ? al_data        :
                   mem_wb_sel == WB_SEL_ALU   ? mem_alu_result :
                   mem_wb_sel == WB_SEL_IMM   ? mem_imm        : mem_pc_plus4;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_rd          <= '0;
            q_reg_write   <= 1'b0;
            q_funct3      <= '0;
            q_offset      <= '0;
            t_cnt         <= '0;
            rf_reg_write  <= 1'b0;
            rf_rd         <= '0;
            rf_write_data <= '0;
            load_err      <= 1'b0;
            retire_cnt    <= '0;
        end else begin
            if (accept) begin
                q_rd        <= mem_rd;
                q_reg_write <= mem_reg_write;
                q_funct3    <= mem_funct3;
                q_offset    <= mem_alu_result[1:0];
                t_cnt       <= '0;
            end else if (in_wait) begin
                t_cnt <= t_cnt + 1'b1;
            end
            rf_reg_write <= strobe_d;
            load_err     <= err_d;
            if (strobe_d) begin
                rf_rd         <= rd_d;
                rf_write_data <= data_d;
            end
            if (state == WRITE) retire_cnt <= retire_cnt + 1'b1;
        end
    end

endmodule
